// File: rtl/axil_master_bridge.sv
// AXI-Lite single-outstanding master bridge.
// A simple valid/ready request port drives one AXI-Lite transaction at a time.
// The result comes back on a valid/ready response port.
// A watchdog aborts any transaction that the bus leaves hanging.
module axil_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // AXI-Lite master
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int              CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic             busy;
    logic             final_done;
    logic             wd_abort;
    logic             aw_ok;
    logic             w_ok;

    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_RESP);

    // A response arriving in the expiry cycle still wins over the watchdog
    assign final_done = ((state == WR_RESP) && m_axil_bvalid) ||
                        ((state == RD_RESP) && m_axil_rvalid);
    assign wd_abort   = WD_EN && busy && (wd_cnt == WD_LAST) && !final_done;

    // A channel counts as done once its valid has dropped, or if it handshakes this cycle
    assign aw_ok = !m_axil_awvalid || m_axil_awready;
    assign w_ok  = !m_axil_wvalid  || m_axil_wready;

    // Transaction FSM; every outward-facing signal is registered here
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            wd_cnt         <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            rsp_timeout    <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else if (wd_abort) begin
            // Hung bus: withdraw everything and report a timeout
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_err        <= 1'b1;
            rsp_timeout    <= 1'b1;
            rsp_rdata      <= '0;
            state          <= RSP;
        end else begin
            if (busy) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wd_cnt    <= '0;
                        if (req_we) begin
                            m_axil_awaddr  <= req_addr;
                            m_axil_wdata   <= req_wdata;
                            m_axil_wstrb   <= req_wstrb;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WR_REQ;
                        end else begin
                            m_axil_araddr  <= req_addr;
                            m_axil_arvalid <= 1'b1;
                            state          <= RD_REQ;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (m_axil_awvalid && m_axil_awready) begin
                        m_axil_awvalid <= 1'b0;
                    end
                    if (m_axil_wvalid && m_axil_wready) begin
                        m_axil_wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        m_axil_bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= (m_axil_bresp != 2'b00);
                        rsp_timeout   <= 1'b0;
                        rsp_rdata     <= '0;
                        state         <= RSP;
                    end
                end
                RD_REQ: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= (m_axil_rresp != 2'b00);
                        rsp_timeout   <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axil_master_bridge.md
AXIL_MASTER_BRIDGE -- requirements
Module: axil_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, transaction watchdog limit; 0 disables the watchdog.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-006 SHALL have ports:
  aclk  in  1  sole clock, rising edge
  aresetn  in  1  asynchronous active-low reset
  req_valid  in  1  request offered
  req_ready  out  1  bridge can accept a request
  req_we  in  1  1 = write, 0 = read
  req_addr  in  ADDR_WIDTH  byte address
  req_wdata  in  DATA_WIDTH  write data
  req_wstrb  in  STRB_WIDTH  write byte enables
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
  rsp_err  out  1  SLVERR/DECERR or timeout
  rsp_timeout  out  1  watchdog expired
  m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI-Lite master signals, widths from parameters

Function
REQ-007 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-008 SHALL drive req_ready=1 only in IDLE; accept on req_valid&&req_ready and register addr/wdata/wstrb/we.
REQ-009 SHALL go IDLE->WR_REQ on accepted write, IDLE->RD_REQ on accepted read; AW/W or AR valid asserted the cycle after acceptance.
REQ-010 SHALL in WR_REQ assert awvalid and wvalid together, drop each independently on its own handshake, hold addr/data/strb stable until handshake.
REQ-011 SHALL go WR_REQ->WR_RESP the cycle after both AW and W handshakes complete, including same-cycle completion.
REQ-012 SHALL assert bready only in WR_RESP; on bvalid capture rsp_err=(bresp!=0), rsp_rdata=0, go to RSP.
REQ-013 SHALL in RD_REQ assert arvalid until arready, then go RD_RESP.
REQ-014 SHALL assert rready only in RD_RESP; on rvalid capture rdata and rsp_err=(rresp!=0), go to RSP.
REQ-015 SHALL drive awprot=arprot=3'b000 constantly.
REQ-016 SHALL in RSP hold rsp_valid=1 and response fields stable until rsp_ready, then return to IDLE the next cycle; rsp_valid&&rsp_ready and new req acceptance never in the same cycle.
REQ-017 SHALL clear watchdog counter on request acceptance and increment it each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
REQ-018 SHALL, when TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without completion, drop all AXI valids/readys, go to RSP with rsp_timeout=1, rsp_err=1, rsp_rdata=0 (deliberate abort of a hung bus).
REQ-019 SHALL ignore bvalid/rvalid outside WR_RESP/RD_RESP (bready/rready low).
REQ-020 SHALL complete at most one outstanding transaction; minimum write/read turnaround with zero-wait slave: accept N, valids N+1, resp-ready N+2, rsp_valid N+3.

Reset
REQ-021 SHALL on aresetn low immediately force state IDLE and all outputs to 0: awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, addresses, data, strobes; req_ready=1 after reset release.
REQ-022 SHALL abandon any in-flight transaction on reset with no response issued.

Verification
REQ-023 Write 0x1000/0xDEADBEEF/strb 0xF, slave ready immediately, bresp=0 -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-024 Read 0x2004, slave rdata=0x12345678 rresp=0 after 5-cycle delay -> rsp_rdata=0x12345678, rsp_err=0, arvalid high until arready.
REQ-025 Write with wready 4 cycles before awready -> wvalid drops after W handshake, awvalid held, bready only after both handshakes.
REQ-026 Read returning rresp=2'b10 -> rsp_err=1, rsp_timeout=0; rsp_valid held 3 cycles until rsp_ready, req_ready low meanwhile.
REQ-027 TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles, rsp_valid with rsp_timeout=1, rsp_err=1.
REQ-028 aresetn asserted while in WR_RESP -> all valids/readys low same cycle, no rsp_valid, next request serviced normally.
